// File: rtl/mac_accumulator.sv
// Nibble-serial multiply-accumulate back end: folds an LSB-first 4-bit product stream
// into an ACC_WIDTH accumulator and reads it back LSB nibble first.
module mac_accumulator #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned ACC_WIDTH = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] prod_nibble,
  input  logic       prod_valid,
  input  logic       prod_done,
  input  logic       clear,
  input  logic       read_req,
  output logic [3:0] acc_out,
  output logic       acc_out_valid,
  output logic       acc_out_last,
  output logic       ready,
  output logic       overflow,
  output logic       protocol_err
);

  localparam int unsigned N  = BIT_WIDTH / 4;
  localparam int unsigned M  = ACC_WIDTH / 4;
  localparam int unsigned IW = $clog2(M + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_CARRY,
    S_READ
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   carry_q, carry_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [3:0]             out_nib_q, out_nib_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic                   overflow_q, overflow_d;
  logic                   perr_q, perr_d;

  logic [IW-1:0]          add_idx;
  logic [IW+1:0]          add_sh;
  logic [3:0]             add_op;
  logic                   add_cin;
  logic [ACC_WIDTH-1:0]   acc_shift;
  logic [4:0]             add_sum;
  logic [ACC_WIDTH-1:0]   acc_add;
  logic [ACC_WIDTH-1:0]   rd_shift;

  // Single shared nibble adder; the first nibble of a product always starts at position 0.
  always_comb begin
    add_idx   = (state_q == S_IDLE) ? '0 : idx_q;
    add_sh    = {add_idx, 2'b00};
    add_op    = (state_q == S_CARRY) ? 4'h0 : prod_nibble;
    add_cin   = (state_q == S_IDLE) ? 1'b0 : carry_q;
    acc_shift = acc_q >> add_sh;
    add_sum   = {1'b0, acc_shift[3:0]} + {1'b0, add_op} + {4'b0000, add_cin};
    acc_add   = (acc_q & ~(ACC_WIDTH'(4'hF) << add_sh)) | (ACC_WIDTH'(add_sum[3:0]) << add_sh);
    rd_shift  = acc_q >> {idx_q, 2'b00};
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    out_nib_d   = '0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    overflow_d  = overflow_q;
    perr_d      = perr_q;

    unique case (state_q)
      S_IDLE: begin
        if (clear) begin
          acc_d      = '0;
          carry_d    = 1'b0;
          overflow_d = 1'b0;
          perr_d     = 1'b0;
        end else if (read_req) begin
          // First readout nibble is launched on the accepting edge so valid starts next cycle.
          out_valid_d = 1'b1;
          out_nib_d   = acc_q[3:0];
          out_last_d  = (M == 1);
          idx_d       = IW'(1);
          state_d     = S_READ;
        end else if (prod_valid) begin
          acc_d   = acc_add;
          carry_d = add_sum[4];
          idx_d   = IW'(1);
          if (N == 1) begin
            if (M > N) begin
              state_d = S_CARRY;
            end else begin
              overflow_d = overflow_q | add_sum[4];
              carry_d    = 1'b0;
              idx_d      = '0;
            end
          end else begin
            state_d = S_ACCUM;
          end
        end
      end

      S_ACCUM: begin
        if (prod_valid) begin
          acc_d   = acc_add;
          carry_d = add_sum[4];
          idx_d   = idx_q + IW'(1);
          if (idx_q == IW'(N - 1)) begin
            if (M > N) begin
              state_d = S_CARRY;
            end else begin
              overflow_d = overflow_q | add_sum[4];
              carry_d    = 1'b0;
              idx_d      = '0;
              state_d    = S_IDLE;
            end
          end else if (prod_done) begin
            state_d = S_CARRY;
          end
        end else if (prod_done) begin
          // Truncated product: CARRY walks the pending carry through the zero nibbles too.
          state_d = S_CARRY;
        end
      end

      S_CARRY: begin
        perr_d  = perr_q | prod_valid;
        acc_d   = acc_add;
        carry_d = add_sum[4];
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(M - 1)) begin
          overflow_d = overflow_q | add_sum[4];
          carry_d    = 1'b0;
          idx_d      = '0;
          state_d    = S_IDLE;
        end
      end

      S_READ: begin
        perr_d = perr_q | prod_valid;
        if (idx_q == IW'(M)) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
          out_nib_d   = rd_shift[3:0];
          out_last_d  = (idx_q == IW'(M - 1));
          idx_d       = idx_q + IW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      out_nib_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      out_nib_q   <= out_nib_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
      perr_q      <= perr_d;
    end
  end

  assign acc_out       = out_nib_q;
  assign acc_out_valid = out_valid_q;
  assign acc_out_last  = out_last_q;
  assign ready         = (state_q == S_IDLE);
  assign overflow      = overflow_q;
  assign protocol_err  = perr_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed scenarios plus random products,
// checked against an arithmetic model of the accumulator (sum mod 2^24).
module tb_mac_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] prod_nibble = 4'h0;
  logic       prod_valid = 1'b0;
  logic       prod_done = 1'b0;
  logic       clear = 1'b0;
  logic       read_req = 1'b0;
  logic [3:0] acc_out;
  logic       acc_out_valid;
  logic       acc_out_last;
  logic       ready;
  logic       overflow;
  logic       protocol_err;

  always #5 clk = ~clk;

  mac_accumulator #(.BIT_WIDTH(16), .ACC_WIDTH(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .prod_nibble  (prod_nibble),
    .prod_valid   (prod_valid),
    .prod_done    (prod_done),
    .clear        (clear),
    .read_req     (read_req),
    .acc_out      (acc_out),
    .acc_out_valid(acc_out_valid),
    .acc_out_last (acc_out_last),
    .ready        (ready),
    .overflow     (overflow),
    .protocol_err (protocol_err)
  );

  int checks = 0;
  int failures = 0;

  longint unsigned acc_m = 0;
  bit              ovf_m = 1'b0;
  bit              perr_m = 1'b0;
  logic [3:0]      exp_q[$];
  int              run_len = 0;
  logic [3:0]      mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_model(input longint unsigned val);
    acc_m = acc_m + val;
    if (acc_m >= (64'd1 << 24)) begin
      ovf_m = 1'b1;
      acc_m = acc_m - (64'd1 << 24);
    end
  endtask

  task automatic zero_model();
    acc_m  = 0;
    ovf_m  = 1'b0;
    perr_m = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_ready"}, ready, 1'b1);
    chk({tag, "_overflow"}, overflow, ovf_m);
    chk({tag, "_protocol_err"}, protocol_err, perr_m);
  endtask

  task automatic wait_ready(input int exp_lat);
    int n = 0;
    while (!ready && n < 50) begin
      tick();
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
    else if (exp_lat >= 0) chk("ready_low_cycles", n, exp_lat);
  endtask

  // Gaps may carry clear/read_req pulses, which must be ignored mid-product.
  task automatic send_product(input logic [15:0] val, input int gap, input bit noise);
    for (int i = 0; i < 4; i++) begin
      prod_nibble = val[4*i +: 4];
      prod_valid  = 1'b1;
      tick();
      prod_valid  = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          clear    = noise && (g == 0);
          read_req = noise && (g != 0);
          tick();
          clear    = 1'b0;
          read_req = 1'b0;
        end
      end
    end
    prod_nibble = 4'h0;
    add_model(val);
    wait_ready(2);
  endtask

  task automatic send_truncated(input logic [15:0] val, input int k);
    logic [15:0] kept;
    kept = '0;
    for (int i = 0; i < k; i++) begin
      prod_nibble = val[4*i +: 4];
      kept[4*i +: 4] = val[4*i +: 4];
      prod_valid  = 1'b1;
      tick();
    end
    prod_valid  = 1'b0;
    prod_nibble = 4'h0;
    prod_done   = 1'b1;
    tick();
    prod_done   = 1'b0;
    add_model(kept);
    wait_ready(-1);
  endtask

  task automatic do_read(input bit inject);
    int n = 0;
    for (int i = 0; i < 6; i++) exp_q.push_back(acc_m[4*i +: 4]);
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    chk("valid_after_accept", acc_out_valid, 1'b1);
    if (inject) begin
      prod_nibble = 4'hF;
      prod_valid  = 1'b1;
      tick();
      prod_valid  = 1'b0;
      prod_nibble = 4'h0;
      perr_m      = 1'b1;
    end
    while ((exp_q.size() != 0 || !ready) && n < 30) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || !ready) begin
      chk("read_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    check_flags("post_read");
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    zero_model();
    check_flags("post_clear");
  endtask

  // Readout monitor: every valid nibble is compared to the model's snapshot.
  always @(negedge clk) begin
    if (!rst) begin
      if (acc_out_valid) begin
        run_len++;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("acc_out", acc_out, mon_e);
          chk("acc_out_last", acc_out_last, exp_q.size() == 0);
          chk("ready_in_read", ready, 1'b0);
        end
      end else begin
        if (run_len != 0) begin
          chk("read_len", run_len, 6);
          run_len = 0;
        end
        chk("idle_out_zero", {acc_out, acc_out_last}, 5'h00);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [15:0] v;

    #2;
    chk("rst_ready", ready, 1'b1);
    chk("rst_valid", acc_out_valid, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_perr", protocol_err, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Async reset mid-clock, with a partially delivered product in flight.
    send_product(16'h1111, 0, 1'b0);
    do_read(1'b1);
    chk("pre_rst_perr", protocol_err, 1'b1);
    for (int i = 0; i < 2; i++) begin
      prod_nibble = 4'h7;
      prod_valid  = 1'b1;
      tick();
    end
    prod_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_ready", ready, 1'b1);
    chk("async_rst_overflow", overflow, 1'b0);
    chk("async_rst_perr", protocol_err, 1'b0);
    chk("async_rst_valid", acc_out_valid, 1'b0);
    zero_model();
    #2;
    rst = 1'b0;
    tick();
    do_read(1'b0);

    // Two small products.
    send_product(16'h0006, 0, 1'b0);
    send_product(16'h0374, 0, 1'b0);
    chk("model_sum_37a", acc_m, 64'h37A);
    do_read(1'b0);

    // Carry ripples into the upper accumulator nibbles.
    do_clear();
    send_product(16'hFFFF, 0, 1'b0);
    send_product(16'h0001, 0, 1'b0);
    chk("model_sum_10000", acc_m, 64'h010000);
    do_read(1'b0);

    // Overflow past 2^24.
    do_clear();
    repeat (257) send_product(16'hFFFF, 0, 1'b0);
    chk("model_wrap", acc_m, 64'h00FEFF);
    chk("model_ovf", ovf_m, 1'b1);
    do_read(1'b0);
    chk("overflow_set", overflow, 1'b1);
    do_clear();
    chk("overflow_cleared", overflow, 1'b0);
    do_read(1'b0);

    // Gapped delivery with ignored control pulses, then protocol error during READ.
    send_product(16'h1234, 3, 1'b1);
    chk("model_gapped", acc_m, 64'h1234);
    do_read(1'b0);
    do_clear();
    send_product(16'h1234, 0, 1'b0);
    do_read(1'b1);
    chk("perr_set", protocol_err, 1'b1);
    do_read(1'b0);

    // Early prod_done, then reset in the middle of a product.
    do_clear();
    send_truncated(16'h0005, 1);
    chk("model_trunc", acc_m, 64'h5);
    do_read(1'b0);
    for (int i = 0; i < 2; i++) begin
      prod_nibble = 4'h9;
      prod_valid  = 1'b1;
      tick();
    end
    prod_valid = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    zero_model();
    tick();
    do_read(1'b0);

    // Random mix.
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      v = 16'($urandom_range(0, 65535));
      if (r < 6) send_product(v, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      else if (r == 6) do_read(1'($urandom_range(0, 1)));
      else if (r == 7) do_clear();
      else if (r == 8) send_truncated(v, $urandom_range(1, 3));
      else send_product(16'hFFFF, 0, 1'b0);
    end
    do_read(1'b0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
